// File: rtl/host_cmd_framer_pkg.sv
// host_cmd_framer_pkg
// Shared constants for the host command framer: FSM state encodings,
// response status bytes, NAK error codes, the NAK decision record and a
// small helper used to size the shared timeout counters.
package host_cmd_framer_pkg;

    // FSM state encodings (plain constants so legacy code can compare them).
    localparam logic [3:0] ST_HUNT  = 4'd0;
    localparam logic [3:0] ST_CMD   = 4'd1;
    localparam logic [3:0] ST_ADDR  = 4'd2;
    localparam logic [3:0] ST_DATA  = 4'd3;
    localparam logic [3:0] ST_CHK   = 4'd4;
    localparam logic [3:0] ST_EXEC  = 4'd5;
    localparam logic [3:0] ST_WAIT  = 4'd6;
    localparam logic [3:0] ST_RESP0 = 4'd7;
    localparam logic [3:0] ST_RESP1 = 4'd8;

    // Frame marker and response status bytes.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_BYTE     = 8'h5A;
    localparam logic [7:0] NAK_BYTE     = 8'hE1;

    // NAK payload codes.
    localparam logic [7:0] ERR_CHECKSUM     = 8'h01;
    localparam logic [7:0] ERR_BYTE_TIMEOUT = 8'h02;
    localparam logic [7:0] ERR_EXEC_TIMEOUT = 8'h03;

    // Result of the per-cycle NAK decision.
    typedef struct packed {
        logic       take;
        logic [7:0] code;
    } nak_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/host_cmd_framer_if.sv
// host_cmd_framer_if
// Bundles the framer's byte streams and handler handshake.
//   rx_data/rx_valid        : byte stream from the UART receiver (no backpressure)
//   tx_data/tx_valid/tx_ready : response stream to the UART transmitter
//   hdl_cmd/addr/data/exec  : command issue to the SPI command handler
//   hdl_busy/hdl_rdata      : handler status and result
//   frame_err               : one-cycle pulse on any NAK decision
// modport master = framer side, modport slave = environment side.
interface host_cmd_framer_if #(parameter int W = 8) ();
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] hdl_cmd;
    logic [W-2:0] hdl_addr;
    logic [W-1:0] hdl_data;
    logic         hdl_exec;
    logic         hdl_busy;
    logic [W-1:0] hdl_rdata;
    logic         frame_err;

    modport master (
        input  rx_data, rx_valid, tx_ready, hdl_busy, hdl_rdata,
        output tx_data, tx_valid, hdl_cmd, hdl_addr, hdl_data, hdl_exec, frame_err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, hdl_busy, hdl_rdata,
        input  tx_data, tx_valid, hdl_cmd, hdl_addr, hdl_data, hdl_exec, frame_err
    );
endinterface

// File: rtl/host_cmd_framer_timeout_counter.sv
// host_cmd_framer_timeout_counter
// Saturating idle-cycle counter. Counts cycles with en high, restarts on clr.
// expired is high in the enabled cycle that would be the limit-th counted
// cycle, so the owner can act in that same cycle.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count at zero (wins over en)
//   en       : count this cycle
//   limit    : number of counted cycles that constitutes a timeout (>= 1)
//   expired  : timeout reached this cycle
module host_cmd_framer_timeout_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt < limit)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt >= (limit - W'(1)));

endmodule

// File: rtl/host_cmd_framer.sv
// host_cmd_framer
// Assembles SYNC/CMD/ADDR/DATA/CHK frames from the host UART byte stream,
// issues valid frames to the SPI command handler as a one-cycle exec, waits
// for the handler, and returns a 2-byte ACK (status, rdata) or NAK
// (status, error code) on the transmit stream.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : host_cmd_framer_if.master (rx/tx streams, handler handshake,
//              frame_err pulse)
module host_cmd_framer
    import host_cmd_framer_pkg::*;
#(
    parameter int                      PACKAGE_SIZE = 8,
    parameter logic [PACKAGE_SIZE-1:0] SYNC_BYTE    = PACKAGE_SIZE'(SYNC_DEFAULT),
    parameter int                      BYTE_TIMEOUT = 100000,
    parameter int                      EXEC_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    host_cmd_framer_if.master bus
);

    localparam int W     = PACKAGE_SIZE;
    localparam int CNT_W = $clog2(max_int(BYTE_TIMEOUT, EXEC_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] BYTE_LIMIT = CNT_W'(BYTE_TIMEOUT);
    localparam logic [CNT_W-1:0] EXEC_LIMIT = CNT_W'(EXEC_TIMEOUT);

    logic [3:0]   state;
    logic         addr_msb;    // ADDR bit dropped from hdl_addr, still part of CHK
    logic [W-1:0] payload;     // second response byte (rdata or error code)
    logic         wait_first;  // first WAIT cycle: handler may not have raised busy yet

    logic         in_frame;
    logic         wait_done;
    logic [W-1:0] chk_exp;
    logic         byte_exp;
    logic         exec_exp;
    nak_t         nak;

    assign in_frame  = state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
    assign wait_done = (state == ST_WAIT) && !wait_first && !bus.hdl_busy;
    assign chk_exp   = bus.hdl_cmd ^ {addr_msb, bus.hdl_addr} ^ bus.hdl_data;

    // A byte arriving in the expiry cycle disables counting, so it wins.
    host_cmd_framer_timeout_counter #(.W(CNT_W)) u_byte_to (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rx_valid || !in_frame),
        .en      (in_frame && !bus.rx_valid),
        .limit   (BYTE_LIMIT),
        .expired (byte_exp)
    );

    host_cmd_framer_timeout_counter #(.W(CNT_W)) u_exec_to (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ST_WAIT),
        .en      ((state == ST_WAIT) && bus.hdl_busy),
        .limit   (EXEC_LIMIT),
        .expired (exec_exp)
    );

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        nak = '0;
        if ((state == ST_CHK) && bus.rx_valid && (bus.rx_data != chk_exp)) begin
            nak = '{take: 1'b1, code: ERR_CHECKSUM};
        end else if (in_frame && byte_exp) begin
            nak = '{take: 1'b1, code: ERR_BYTE_TIMEOUT};
        end else if ((state == ST_WAIT) && !wait_done && exec_exp) begin
            nak = '{take: 1'b1, code: ERR_EXEC_TIMEOUT};
        end
    end

    // Flags the error in the decision cycle itself; suppressed under reset.
    assign bus.frame_err = nak.take && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HUNT;
            addr_msb     <= 1'b0;
            payload      <= '0;
            wait_first   <= 1'b0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.hdl_cmd  <= '0;
            bus.hdl_addr <= '0;
            bus.hdl_data <= '0;
            bus.hdl_exec <= 1'b0;
        end else begin
            bus.hdl_exec <= 1'b0;
            if (nak.take) begin
                payload      <= W'(nak.code);
                bus.tx_data  <= W'(NAK_BYTE);
                bus.tx_valid <= 1'b1;
                state        <= ST_RESP0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) state <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (bus.rx_valid) begin
                            bus.hdl_cmd <= bus.rx_data;
                            state       <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (bus.rx_valid) begin
                            bus.hdl_addr <= bus.rx_data[W-2:0];
                            addr_msb     <= bus.rx_data[W-1];
                            state        <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bus.rx_valid) begin
                            bus.hdl_data <= bus.rx_data;
                            state        <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        // A mismatch was already taken as a NAK above.
                        if (bus.rx_valid) begin
                            bus.hdl_exec <= 1'b1;
                            state        <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        wait_first <= 1'b1;
                        state      <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        wait_first <= 1'b0;
                        if (wait_done) begin
                            payload      <= bus.hdl_rdata;
                            bus.tx_data  <= W'(ACK_BYTE);
                            bus.tx_valid <= 1'b1;
                            state        <= ST_RESP0;
                        end
                    end
                    ST_RESP0: begin
                        if (bus.tx_ready) begin
                            bus.tx_data <= payload;
                            state       <= ST_RESP1;
                        end
                    end
                    ST_RESP1: begin
                        if (bus.tx_ready) begin
                            bus.tx_valid <= 1'b0;
                            state        <= ST_HUNT;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_framer.sv
// tb_host_cmd_framer
// Directed bench for host_cmd_framer: good frames, checksum NAK, byte and
// exec timeouts, garbage before SYNC, tx backpressure and reset in WAIT.
// A small handler model answers hdl_exec; a monitor collects accepted tx
// bytes and watches tx hold stability.
module tb_host_cmd_framer;

    localparam int BT = 20;
    localparam int ET = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    host_cmd_framer_if #(.W(8)) bus_if ();

    host_cmd_framer #(
        .PACKAGE_SIZE (8),
        .SYNC_BYTE    (8'hA5),
        .BYTE_TIMEOUT (BT),
        .EXEC_TIMEOUT (ET)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         exec_count = 0;
    int         fe_count   = 0;
    int         stab_err   = 0;
    int         busy_cycles = 4;
    bit         stuck      = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] tx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; leaves rx_valid low on the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while ((tx_q.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_tx_count"}, tx_q.size(), n);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    // Handler model: busy from the exec cycle's falling edge for busy_cycles
    // falling edges, then rdata is presented as busy drops.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.hdl_exec === 1'b1) begin
                exec_count++;
                bus_if.hdl_busy = 1'b1;
                if (!stuck) begin
                    repeat (busy_cycles) @(negedge clk);
                    bus_if.hdl_rdata = model_rdata;
                    bus_if.hdl_busy  = 1'b0;
                end
            end
        end
    end

    // Monitor: samples 2 time units after the falling edge, when both the
    // bench inputs and DUT outputs are settled for the coming rising edge.
    initial begin
        logic       prev_pend = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (prev_pend && (!bus_if.tx_valid || (bus_if.tx_data !== prev_data))) stab_err++;
                if (bus_if.tx_valid && bus_if.tx_ready) tx_q.push_back(bus_if.tx_data);
                if (bus_if.frame_err) fe_count++;
            end
            prev_pend = bus_if.tx_valid && !bus_if.tx_ready && !rst;
            prev_data = bus_if.tx_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int exp_exec = 0;
        bus_if.rx_data   = 8'h00;
        bus_if.rx_valid  = 1'b0;
        bus_if.tx_ready  = 1'b1;
        bus_if.hdl_busy  = 1'b0;
        bus_if.hdl_rdata = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_tx_valid",  bus_if.tx_valid,  0);
        check("rst_tx_data",   bus_if.tx_data,   0);
        check("rst_hdl_exec",  bus_if.hdl_exec,  0);
        check("rst_hdl_cmd",   bus_if.hdl_cmd,   0);
        check("rst_hdl_addr",  bus_if.hdl_addr,  0);
        check("rst_hdl_data",  bus_if.hdl_data,  0);
        check("rst_frame_err", bus_if.frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1: good frame A5 10 05 3C 29, handler busy 4 cycles, rdata 77
        model_rdata = 8'h77;
        tx_q.delete();
        send_frame(8'h10, 8'h05, 8'h3C, 8'h29);
        exp_exec++;
        #2;
        check("t1_exec_latency", bus_if.hdl_exec, 1);
        k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!bus_if.tx_valid && (k < 50));
        check("t1_ack_latency", k, 5);
        check("t1_status_data", bus_if.tx_data, 8'h5A);
        @(negedge clk);
        #2;
        check("t1_payload_next", {bus_if.tx_valid, bus_if.tx_data}, {1'b1, 8'h77});
        @(negedge clk);
        #2;
        check("t1_tx_idle", bus_if.tx_valid, 0);
        check("t1_hdl_cmd",  bus_if.hdl_cmd,  8'h10);
        check("t1_hdl_addr", bus_if.hdl_addr, 7'h05);
        check("t1_hdl_data", bus_if.hdl_data, 8'h3C);
        expect_tx("t1_tx0", 8'h5A);
        expect_tx("t1_tx1", 8'h77);
        check("t1_exec_count", exec_count, exp_exec);
        check("t1_no_frame_err", fe_count, 0);
        @(negedge clk);

        // T2: same frame with CHK=00 -> NAK 01, no exec, frame_err in strobe cycle
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h05);
        send_byte(8'h3C);
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b1;
        #2;
        check("t2_frame_err", bus_if.frame_err, 1);
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        #2;
        check("t2_frame_err_width", bus_if.frame_err, 0);
        @(negedge clk);
        wait_tx(2, 20, "t2");
        expect_tx("t2_tx0", 8'hE1);
        expect_tx("t2_tx1", 8'h01);
        check("t2_exec_count", exec_count, exp_exec);
        check("t2_fe_count", fe_count, 1);

        // T3: A5 10 then silence -> NAK 02 on the BT-th idle cycle
        send_byte(8'hA5);
        send_byte(8'h10);
        k = 1;
        #2;
        while (!bus_if.frame_err && (k < BT + 10)) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("t3_timeout_cycles", k, BT);
        @(negedge clk);
        wait_tx(2, 20, "t3");
        expect_tx("t3_tx0", 8'hE1);
        expect_tx("t3_tx1", 8'h02);
        check("t3_fe_count", fe_count, 2);

        // T3b: byte lands exactly on the expiry cycle -> byte wins, ACK
        model_rdata = 8'h5C;
        send_byte(8'hA5);
        send_byte(8'h11);
        repeat (BT - 1) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h10);
        exp_exec++;
        wait_tx(2, 30, "t3b");
        expect_tx("t3b_tx0", 8'h5A);
        expect_tx("t3b_tx1", 8'h5C);
        check("t3b_fe_count", fe_count, 2);
        check("t3b_exec_count", exec_count, exp_exec);

        // T4: garbage 00 FF 12 then A5 01 7F 80 FE -> single ACK
        model_rdata = 8'hC3;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_frame(8'h01, 8'h7F, 8'h80, 8'hFE);
        exp_exec++;
        wait_tx(2, 30, "t4");
        expect_tx("t4_tx0", 8'h5A);
        expect_tx("t4_tx1", 8'hC3);
        check("t4_hdl_addr", bus_if.hdl_addr, 7'h7F);
        repeat (10) @(negedge clk);
        check("t4_single_ack", tx_q.size(), 0);
        check("t4_exec_count", exec_count, exp_exec);

        // T5: handler stuck busy -> NAK 03; bytes during WAIT dropped
        stuck = 1'b1;
        send_frame(8'h30, 8'h40, 8'h50, 8'h20);
        exp_exec++;
        repeat (3) @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h11);
        wait_tx(2, ET + 40, "t5");
        expect_tx("t5_tx0", 8'hE1);
        expect_tx("t5_tx1", 8'h03);
        check("t5_hdl_cmd_kept", bus_if.hdl_cmd, 8'h30);
        check("t5_fe_count", fe_count, 3);
        check("t5_exec_count", exec_count, exp_exec);
        stuck = 1'b0;
        bus_if.hdl_busy = 1'b0;
        @(negedge clk);

        // T6: tx_ready low for 10 cycles while status is pending
        model_rdata = 8'h77;
        bus_if.tx_ready = 1'b0;
        send_frame(8'h10, 8'h05, 8'h3C, 8'h29);
        exp_exec++;
        k = 0;
        while (!bus_if.tx_valid && (k < 30)) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        #2;
        check("t6_held_valid", bus_if.tx_valid, 1);
        check("t6_held_data", bus_if.tx_data, 8'h5A);
        check("t6_nothing_sent", tx_q.size(), 0);
        @(negedge clk);
        bus_if.tx_ready = 1'b1;
        wait_tx(2, 20, "t6");
        expect_tx("t6_tx0", 8'h5A);
        expect_tx("t6_tx1", 8'h77);
        check("t6_tx_stable", stab_err, 0);

        // T7: reset asserted in WAIT -> outputs zero, no response, no re-exec
        stuck = 1'b1;
        send_frame(8'h44, 8'h12, 8'h34, 8'h62);
        exp_exec++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("t7_rst_tx_valid",  bus_if.tx_valid,  0);
        check("t7_rst_tx_data",   bus_if.tx_data,   0);
        check("t7_rst_hdl_cmd",   bus_if.hdl_cmd,   0);
        check("t7_rst_hdl_addr",  bus_if.hdl_addr,  0);
        check("t7_rst_hdl_data",  bus_if.hdl_data,  0);
        check("t7_rst_hdl_exec",  bus_if.hdl_exec,  0);
        check("t7_rst_frame_err", bus_if.frame_err, 0);
        @(negedge clk);
        stuck = 1'b0;
        bus_if.hdl_busy = 1'b0;
        rst = 1'b0;
        repeat (ET + BT) @(negedge clk);
        check("t7_no_response", tx_q.size(), 0);
        check("t7_tx_idle", bus_if.tx_valid, 0);
        check("t7_exec_count", exec_count, exp_exec);
        send_frame(8'h10, 8'h05, 8'h3C, 8'h29);
        exp_exec++;
        wait_tx(2, 30, "t7");
        expect_tx("t7_tx0", 8'h5A);
        expect_tx("t7_tx1", 8'h77);
        check("t7_exec_after", exec_count, exp_exec);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
